// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and encodings for the 8-way round-robin nibble arbiter.
// The arbiter top, the pick logic and the selector all import this package.
package mux8_rr_arbiter_pkg;

  localparam int N_REQ  = 8;
  localparam int DATA_W = 4;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_t;

endpackage

// File: rtl/mux8_rr_arbiter_mux.sv
// The shared 8:1 selector of 4-bit nibbles; requester k sits at bits [4k+3:4k].
module mux8x4
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       data_out
);

  assign data_out = data_in[sel*DATA_W +: DATA_W];

endmodule

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational winner pick: the first set request scanning from ptr (round-robin),
// or from index 0 (fixed priority). Kept separate so it can be verified on its own.
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [SEL_W-1:0] w_start;
  logic [SEL_W-1:0] w_idx;

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    win     = '0;
    w_idx   = '0;
    w_start = (mode == MODE_FIXED) ? '0 : ptr;
    // Scan from the far end so the offset closest to w_start is written last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = w_start + SEL_W'(k);
      if (req[w_idx]) win = w_idx;
    end
    any = |req;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin / fixed-priority sequencer sharing one 8:1 nibble selector between
// eight requesters, with a registered valid/ready output stage and one-hot ack.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic                    mode,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic [SEL_W-1:0]        sel,
  output logic [N_REQ-1:0]        ack,
  output logic [CNT_W-1:0]        xfer_cnt
);

  state_t              r_state;
  logic [SEL_W-1:0]    r_ptr;
  logic [SEL_W-1:0]    r_sel;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_cnt;

  logic [SEL_W-1:0]    w_win;
  logic                w_any;
  logic                w_grant;
  logic                w_hs;
  logic [SEL_W-1:0]    w_sel_next;
  logic [DATA_W-1:0]   w_mux;

  rr_pick8 u_pick (
    .req  (req),
    .ptr  (r_ptr),
    .mode (mode),
    .win  (w_win),
    .any  (w_any)
  );

  // The selector sees the next-state select so the winner's nibble is captured
  // on the same edge that issues the grant.
  assign w_grant    = (r_state == IDLE) && w_any;
  assign w_sel_next = w_grant ? w_win : r_sel;

  mux8x4 u_mux (
    .data_in  (data_in),
    .sel      (w_sel_next),
    .data_out (w_mux)
  );

  assign w_hs = (r_state == BUSY) && out_ready;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= BUSY;
            r_sel   <= w_win;
            r_data  <= w_mux;
          end
        end
        BUSY: begin
          if (out_ready) begin
            r_state <= IDLE;
            r_ptr   <= r_sel + SEL_W'(1);
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == BUSY);
  assign out_data  = r_data;
  assign out_src   = r_sel;
  assign sel       = r_sel;
  assign xfer_cnt  = r_cnt;
  assign ack       = w_hs ? (N_REQ'(1) << r_sel) : '0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter with hand-computed expectations.
module tb_mux8_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic [31:0] data_in;
  logic        mode;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [2:0]  out_src;
  logic [2:0]  sel;
  logic [7:0]  ack;
  logic [7:0]  xfer_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mux8_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .sel       (sel),
    .ack       (ack),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = 8'hFF;
    data_in   = 32'h87654321;
    mode      = 1'b0;
    out_ready = 1'b0;

    // Reset with every request high.
    step();
    step();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ack",   32'(ack),       0);
    check("rst_cnt",   32'(xfer_cnt),  0);
    check("rst_sel",   32'(sel),       0);
    check("rst_src",   32'(out_src),   0);
    check("rst_data",  32'(out_data),  0);
    rst = 1'b0;
    step();
    check("first_valid", 32'(out_valid), 1);
    check("first_src",   32'(out_src),   0);
    check("first_data",  32'(out_data),  1);
    out_ready = 1'b1;
    #1;
    check("first_ack", 32'(ack), 32'h01);
    step();
    check("first_done_valid", 32'(out_valid), 0);
    check("first_done_cnt",   32'(xfer_cnt),  1);

    // Single request from index 5.
    out_ready = 1'b0;
    req       = 8'h00;
    do_reset();
    data_in   = 32'h00A00000;
    req       = 8'h20;
    out_ready = 1'b1;
    check("single_idle_valid", 32'(out_valid), 0);
    step();
    check("single_valid", 32'(out_valid), 1);
    check("single_src",   32'(out_src),   5);
    check("single_sel",   32'(sel),       5);
    check("single_data",  32'(out_data),  32'hA);
    check("single_ack",   32'(ack),       32'h20);
    step();
    req = 8'h00;
    check("single_cnt",   32'(xfer_cnt),  1);
    check("single_ack0",  32'(ack),       0);

    // Round-robin fairness: 9 transfers, order 0..7 then wrap to 0.
    out_ready = 1'b0;
    do_reset();
    mode      = 1'b0;
    data_in   = 32'hFEDCBA98;
    req       = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [2:0] e;
      e = 3'(i);
      step();
      check($sformatf("rr_src%0d", i),  32'(out_src),  32'(e));
      check($sformatf("rr_data%0d", i), 32'(out_data), 32'(4'(8 + e)));
      check($sformatf("rr_ack%0d", i),  32'(ack),      32'(8'(1) << e));
      step();
      // The served requester drops for a while; the one before it comes back.
      req = 8'hFF & ~(8'(1) << e);
    end
    check("rr_cnt", 32'(xfer_cnt), 9);

    // Fixed priority with req = 0x81, then switch back to round-robin.
    out_ready = 1'b0;
    do_reset();
    mode      = 1'b1;
    req       = 8'h81;
    data_in   = 32'h70000003;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fix_src%0d", i), 32'(out_src), 0);
      check($sformatf("fix_ack%0d", i), 32'(ack),     32'h01);
      step();
    end
    mode = 1'b0;
    step();
    check("fix_to_rr_src",  32'(out_src),  7);
    check("fix_to_rr_data", 32'(out_data), 7);
    step();

    // Backpressure on index 3.
    out_ready = 1'b0;
    do_reset();
    req     = 8'h08;
    data_in = 32'h00006000;
    step();
    check("bp_src",  32'(out_src),  3);
    check("bp_data", 32'(out_data), 6);
    for (int i = 0; i < 5; i++) begin
      data_in = 32'h13579BDF + 32'(i);
      req     = 8'hF7 ^ 8'(i);
      step();
      check($sformatf("bp_hold_data%0d", i),  32'(out_data),  6);
      check($sformatf("bp_hold_sel%0d", i),   32'(sel),       3);
      check($sformatf("bp_hold_ack%0d", i),   32'(ack),       0);
      check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ack", 32'(ack), 32'h08);
    req = 8'h00;
    step();
    check("bp_done_valid", 32'(out_valid), 0);
    check("bp_done_cnt",   32'(xfer_cnt),  1);

    // Reset while BUSY drops the transfer.
    out_ready = 1'b0;
    do_reset();
    req     = 8'h44;
    data_in = 32'h0C000B00;
    step();
    check("rmid_busy_src", 32'(out_src), 2);
    check("rmid_busy_ack", 32'(ack),     0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rmid_valid", 32'(out_valid), 0);
    check("rmid_ack",   32'(ack),       0);
    check("rmid_cnt",   32'(xfer_cnt),  0);
    step();
    check("rmid_rearb_src", 32'(out_src), 2);

    // Counter wraps after 256 handshakes.
    do_reset();
    req       = 8'hFF;
    out_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      step();
      step();
      if (i == 255) check("wrap_255", 32'(xfer_cnt), 255);
    end
    check("wrap_0", 32'(xfer_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one 8-input, 4-bit-wide selector datapath between eight requesters.
- Picks a requester, drives the 3-bit select, and registers the selected 4-bit nibble into a valid/ready output stage.
- Returns a one-hot acknowledge to the served requester.
- Sits between the ALU operand/result sources and the single downstream consumer of the shared 4-bit bus.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 to match the 3-bit select. Other values are unsupported.
- DATA_W, 4, nibble width per requester.
- CNT_W, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  8  request per requester; held high until that requester's ack
- data_in  input  32  packed requester data; requester k occupies bits [4k+3:4k]
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled only in IDLE
- out_ready  input  1  downstream ready
- out_valid  output  1  out_data/out_src valid
- out_data  output  4  captured nibble of the granted requester
- out_src  output  3  index of the granted requester
- sel  output  3  select currently driven to the shared selector; equals out_src while BUSY
- ack  output  8  one-hot, combinational: ack[out_src] = out_valid & out_ready
- xfer_cnt  output  8  completed handshakes; wraps modulo 256

Behaviour:
- Reset (rst high at a clock edge):
  - State = IDLE; out_valid = 0; out_data = 0; out_src = 0; sel = 0; xfer_cnt = 0.
  - Round-robin pointer = 0; ack = 0.
- Reset has priority over everything. If asserted while BUSY, the pending transfer is dropped with no ack; requesters keep req high and are re-arbitrated after reset.
- State machine has two states: IDLE and BUSY.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise choose the winner w:
    - mode = 0: first set bit of req scanning ptr, ptr+1, … ptr+7, modulo 8.
    - mode = 1: lowest set index.
  - At the clock edge: sel = w; out_src = w; out_data = data_in nibble w (taken through the selector using the next-state select); out_valid = 1; go to BUSY.
- Latency: req asserted before edge N gives out_valid high after edge N (one cycle).
- BUSY:
  - out_data, out_src and sel stay stable. req and data_in changes are ignored.
  - A handshake occurs on a cycle where out_ready = 1. In that cycle ack[out_src] = 1 combinationally.
  - At the handshake edge: out_valid = 0; ptr = out_src + 1 (modulo 8, so 7 wraps to 0); xfer_cnt += 1; go to IDLE.
  - In mode 1 the pointer is still updated, so switching back to mode 0 resumes fairly.
- A requester drops req on the cycle after its ack. The mandatory IDLE cycle means a served requester is never double-counted.
- Throughput: at most one transfer per 2 cycles.
- out_ready held low keeps BUSY indefinitely; there is no timeout.
- A requester dropping req while BUSY does not cancel the captured transfer.
- ack is never asserted while out_valid = 0. At most one ack bit is ever high.
- xfer_cnt goes from 255 to 0 on the next handshake; there is no sticky overflow flag.

Decomposition:
- Shared package holds:
  - Constants N_REQ = 8, DATA_W = 4, SEL_W = 3.
  - State encoding: IDLE = 1'b0, BUSY = 1'b1.
  - Mode encoding: MODE_RR = 0, MODE_FIXED = 1.
- One sub-module: rr_pick8. It is combinational, with inputs req[7:0], ptr[2:0], mode and outputs win[2:0], any. This lets the pick logic be verified exhaustively on its own.
- The existing 8:1 4-bit selector is instantiated unchanged for the data path, driven by the next-state select.

Test Plan:
- Reset: hold rst for 2 cycles with req = 8'hFF → out_valid = 0, ack = 0, xfer_cnt = 0, sel = 0. The first grant after reset goes to index 0.
- Single request: req = 8'h20, nibble 5 = 4'hA, out_ready = 1 → out_valid high one cycle after req; out_src = 5; out_data = 4'hA; ack = 8'h20 in that cycle; xfer_cnt = 1.
- Round-robin fairness: req = 8'hFF held, each requester drops req one cycle after its ack and reasserts 2 cycles later, mode = 0, out_ready = 1 → grant order 0,1,2,…,7,0, with ptr wrapping 7→0.
- Fixed priority: mode = 1, req = 8'h81 held continuously → index 0 is granted every transfer. Switching to mode = 0 after 3 transfers makes the next grant index 7 (ptr = 1).
- Backpressure: grant index 3 with out_data = 4'h6, then hold out_ready = 0 for 5 cycles while changing data_in and req → out_data stays 4'h6, sel stays 3, ack stays 0. Raising out_ready completes the transfer with ack = 8'h08.
- Reset mid-transfer and counter wrap: assert rst while BUSY → no ack and out_valid = 0 next cycle. Separately, 256 transfers bring xfer_cnt back to 0.
